// File: rtl/keypad_code_lock_pkg.sv
// Shared definitions for the keypad code lock: lock states, default timing and timer sizing.
// Pure declarations; no logic, no latency, no flow control.
package keypad_code_lock_pkg;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_LOCKOUT  = 2'd2
   } lock_state_t;

   localparam int DEF_UNLOCK_CYC  = 500;
   localparam int DEF_LOCKOUT_CYC = 1000;

   // Wide enough to hold the larger of the two reload values (cycles-1).
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/keypad_code_lock_timer.sv
// Loadable down counter that saturates at zero; load wins over enable.
// Count updates one cycle after load/enable; no backpressure.
module keypad_code_lock_timer #(
   parameter int W = 10
) (
   input  logic         i_clock,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad door lock: buffers a CODE_LEN-digit code, checks it, relocks on a timer, locks out after MAX_TRIES misses.
// All outputs registered, effects visible one cycle after the strobe; strobes are never stalled.
module keypad_code_lock
   import keypad_code_lock_pkg::*;
#(
   parameter int DIGIT_W      = 4,
   parameter int CODE_LEN     = 4,
   parameter int MAX_TRIES    = 3,
   parameter int LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
   parameter int UNLOCK_CYC   = DEF_UNLOCK_CYC,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {CODE_LEN{4'hA}}
) (
   input  logic                             i_clock,
   input  logic                             i_clear,
   input  logic                             i_digit_valid,
   input  logic [DIGIT_W-1:0]               i_digit,
   input  logic                             i_enter,
   input  logic                             i_cancel,
   input  logic                             i_program_req,
   output logic                             o_door_lock,
   output logic                             o_alarm,
   output logic                             o_locked_out,
   output logic                             o_code_updated,
   output logic [$clog2(MAX_TRIES+1)-1:0]   o_attempts
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;
   localparam int CNT_W  = $clog2(CODE_LEN + 1);
   localparam int ATT_W  = $clog2(MAX_TRIES + 1);
   localparam int TMR_W  = timer_width(LOCKOUT_CYC, UNLOCK_CYC);
   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(CODE_LEN);
   localparam logic [ATT_W-1:0] ATT_MAX      = ATT_W'(MAX_TRIES);
   localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);

   lock_state_t       r_state;
   logic [CODE_W-1:0] r_buf;
   logic [CODE_W-1:0] r_code;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_door_lock;
   logic              r_alarm;
   logic              r_locked_out;
   logic              r_code_updated;
   logic [ATT_W-1:0]  r_attempts;

   logic              w_enter;
   logic              w_full_ok;
   logic              w_match;
   logic [ATT_W-1:0]  w_att_inc;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_val;
   logic              w_tmr_en;
   logic              w_tmr_zero;
   logic [TMR_W-1:0]  w_tmr_count_unused;

   assign w_enter   = i_enter & ~i_cancel;
   assign w_full_ok = (r_cnt == CNT_FULL) && !r_ovf;
   assign w_match   = w_full_ok && (r_buf == r_code);
   assign w_att_inc = r_attempts + ATT_W'(1);
   assign w_tmr_en  = (r_state != ST_LOCKED);

   // Every move into LOCKED loads zero so the timer rests at zero there.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (r_state)
         ST_LOCKED: begin
            if (w_enter && w_match) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = UNLOCK_LOAD;
            end else if (w_enter && (w_att_inc == ATT_MAX)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = LOCKOUT_LOAD;
            end
         end
         ST_UNLOCKED: begin
            if (!w_tmr_zero && w_enter && !i_program_req) begin
               w_tmr_load = 1'b1;
            end else if (!w_tmr_zero && w_enter && w_full_ok) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = UNLOCK_LOAD;
            end
         end
         default: ;
      endcase
   end

   keypad_code_lock_timer #(
      .W (TMR_W)
   ) u_timer (
      .i_clock    (i_clock),
      .i_clear    (i_clear),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_count    (w_tmr_count_unused),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         r_state        <= ST_LOCKED;
         r_buf          <= '0;
         r_cnt          <= '0;
         r_ovf          <= 1'b0;
         r_code         <= DEFAULT_CODE;
         r_door_lock    <= 1'b1;
         r_alarm        <= 1'b0;
         r_locked_out   <= 1'b0;
         r_code_updated <= 1'b0;
         r_attempts     <= '0;
      end else begin
         r_code_updated <= 1'b0;

         if ((r_state == ST_LOCKOUT) || i_cancel || i_enter) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (i_digit_valid) begin
            r_buf <= CODE_W'({r_buf, i_digit});
            if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
            else                   r_cnt <= r_cnt + CNT_W'(1);
         end

         case (r_state)
            ST_LOCKED: begin
               if (w_enter && w_match) begin
                  r_state     <= ST_UNLOCKED;
                  r_door_lock <= 1'b0;
                  r_attempts  <= '0;
                  r_alarm     <= 1'b0;
               end else if (w_enter) begin
                  r_attempts <= w_att_inc;
                  if (w_att_inc == ATT_MAX) begin
                     r_state      <= ST_LOCKOUT;
                     r_alarm      <= 1'b1;
                     r_locked_out <= 1'b1;
                  end
               end
            end
            ST_UNLOCKED: begin
               // Expiry beats a simultaneous enter, including a program request.
               if (w_tmr_zero || (w_enter && !i_program_req)) begin
                  r_state     <= ST_LOCKED;
                  r_door_lock <= 1'b1;
               end else if (w_enter && w_full_ok) begin
                  r_code         <= r_buf;
                  r_code_updated <= 1'b1;
               end
            end
            ST_LOCKOUT: begin
               if (w_tmr_zero) begin
                  r_state      <= ST_LOCKED;
                  r_locked_out <= 1'b0;
                  r_attempts   <= '0;
               end
            end
            default: r_state <= ST_LOCKED;
         endcase
      end
   end

   assign o_door_lock    = r_door_lock;
   assign o_alarm        = r_alarm;
   assign o_locked_out   = r_locked_out;
   assign o_code_updated = r_code_updated;
   assign o_attempts     = r_attempts;

endmodule
